// File: rtl/bp_perf_counter.sv
// bp_perf_counter: branch-prediction performance counters with snapshot stream.
// Eight saturating live counters fed by the retire stage and the redirect pulse.
// A snap_req freezes all eight into shadow registers. The shadows are then sent
// as an 8-beat valid/ready stream.
// Optional feature macro: BP_PERF_REPEAT_MISS_EN builds the repeat-miss history
// and counter 5. Without it, counter 5 is constant 0.
module bp_perf_counter #(
    parameter int CNT_W       = 32,
    parameter int REPEAT_DIST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             retire_valid,
    input  logic [31:0]      retire_inst,
    input  logic             mispredict,
    input  logic [31:0]      mispredict_inst,
    input  logic             stall,
    input  logic             count_en,
    input  logic             clear,
    input  logic             snap_req,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_idx,
    output logic [CNT_W-1:0] out_data,
    output logic             out_last
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             snap_load;
    logic [CNT_W-1:0] cnt_q    [8];
    logic [CNT_W-1:0] cnt_d    [8];
    logic [CNT_W-1:0] shadow_q [8];
    logic [CNT_W-1:0] shadow_d [8];
    logic [7:0]       inc;
    logic             rpt_hit;
    logic             is_cond;
    logic             is_jump;
    logic             unused_bits;

    assign is_cond = (retire_inst[6:0] == 7'b1100011);
    assign is_jump = (retire_inst[6:0] == 7'b1101111) || (retire_inst[6:0] == 7'b1100111);

`ifdef BP_PERF_REPEAT_MISS_EN
    logic        hist_vld_q  [REPEAT_DIST];
    logic [31:0] hist_inst_q [REPEAT_DIST];

    // History of {mispredict, inst}; shifts every cycle so distance is in clock cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REPEAT_DIST; i++) begin
                hist_vld_q[i]  <= 1'b0;
                hist_inst_q[i] <= '0;
            end
        end else begin
            hist_vld_q[0]  <= mispredict;
            hist_inst_q[0] <= mispredict_inst;
            for (int i = 1; i < REPEAT_DIST; i++) begin
                hist_vld_q[i]  <= hist_vld_q[i-1];
                hist_inst_q[i] <= hist_inst_q[i-1];
            end
        end
    end

    // Oldest history entry holds the value from exactly REPEAT_DIST cycles ago
    assign rpt_hit = mispredict && hist_vld_q[REPEAT_DIST-1]
                     && (hist_inst_q[REPEAT_DIST-1] == mispredict_inst);
    assign unused_bits = ^retire_inst[31:7];
`else
    assign rpt_hit     = 1'b0;
    assign unused_bits = ^{retire_inst[31:7], mispredict_inst};
`endif

    assign inc[0] = 1'b1;
    assign inc[1] = retire_valid;
    assign inc[2] = retire_valid && (is_cond || is_jump);
    assign inc[3] = retire_valid && is_cond;
    assign inc[4] = mispredict;
    assign inc[5] = rpt_hit;
    assign inc[6] = stall;
    assign inc[7] = retire_valid && is_jump;

    // Live counter next state: clear wins, otherwise saturating increment under count_en
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (clear) begin
            for (int i = 0; i < 8; i++) begin
                cnt_d[i] = '0;
            end
        end else if (count_en) begin
            for (int i = 0; i < 8; i++) begin
                if (inc[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                    cnt_d[i] = cnt_q[i] + ONE;
                end
            end
        end
`ifndef BP_PERF_REPEAT_MISS_EN
        cnt_d[5] = '0;
`endif
    end

    // Live counter and shadow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                cnt_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                cnt_q[i]    <= cnt_d[i];
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    // Shadows capture pre-edge live values, so snap-cycle events are excluded
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            shadow_d[i] = snap_load ? cnt_q[i] : shadow_q[i];
        end
    end

    // Stream FSM next state: accept snapshot in IDLE, walk indices in SEND
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (snap_req) begin
                    state_d   = SEND;
                    idx_d     = 3'd0;
                    snap_load = 1'b1;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (idx_q == 3'd7) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stream FSM state register; async reset aborts any stream in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign busy      = (state_q == SEND);
    assign out_valid = (state_q == SEND);
    assign out_idx   = (state_q == SEND) ? idx_q : 3'd0;
    assign out_data  = (state_q == SEND) ? shadow_q[idx_q] : '0;
    assign out_last  = (state_q == SEND) && (idx_q == 3'd7);

endmodule

// File: tb/tb_bp_perf_counter.sv
// Testbench for bp_perf_counter: a 32-bit and an 8-bit instance share all inputs
// and are compared every cycle against a count-based reference model.
module tb_bp_perf_counter;

    localparam int RD = 4;
`ifdef BP_PERF_REPEAT_MISS_EN
    localparam bit RPT = 1'b1;
`else
    localparam bit RPT = 1'b0;
`endif
    localparam logic [31:0] BEQ  = 32'h00068463;
    localparam logic [31:0] ADD  = 32'h00b50533;
    localparam logic [31:0] JAL  = 32'h008000ef;
    localparam logic [31:0] JALR = 32'h00008067;
    localparam logic [31:0] MA   = 32'hfe0596e3;
    localparam logic [31:0] MB   = 32'hfc0698e3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        retire_valid, mispredict, stall, count_en, clear, snap_req, out_ready;
    logic [31:0] retire_inst, mispredict_inst;
    logic        busy_a, out_valid_a, out_last_a;
    logic [2:0]  out_idx_a;
    logic [31:0] out_data_a;
    logic        busy_b, out_valid_b, out_last_b;
    logic [2:0]  out_idx_b;
    logic [7:0]  out_data_b;

    always #5 clk = ~clk;

    bp_perf_counter #(.CNT_W(32), .REPEAT_DIST(RD)) dut (
        .clk(clk), .rst_n(rst_n), .retire_valid(retire_valid), .retire_inst(retire_inst),
        .mispredict(mispredict), .mispredict_inst(mispredict_inst), .stall(stall),
        .count_en(count_en), .clear(clear), .snap_req(snap_req), .busy(busy_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_idx(out_idx_a),
        .out_data(out_data_a), .out_last(out_last_a)
    );

    bp_perf_counter #(.CNT_W(8), .REPEAT_DIST(RD)) dut8 (
        .clk(clk), .rst_n(rst_n), .retire_valid(retire_valid), .retire_inst(retire_inst),
        .mispredict(mispredict), .mispredict_inst(mispredict_inst), .stall(stall),
        .count_en(count_en), .clear(clear), .snap_req(snap_req), .busy(busy_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_idx(out_idx_b),
        .out_data(out_data_b), .out_last(out_last_b)
    );

    int vectors = 0;
    int miscompares = 0;

    // reference model: plain event counts, saturation applied when read
    longint      m_cnt [8];
    longint      m_shadow [8];
    bit          m_send;
    int          m_idx;
    bit          hmp [$];
    logic [31:0] hinst [$];

    logic [31:0] got32 [8];
    logic [7:0]  got8 [8];

    typedef struct { logic rv; logic [31:0] inst; logic mp; logic snap; } stim_t;
    typedef struct { logic [2:0] idx; logic [31:0] data; logic last; } beat_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_cnt[i] = 0;
            m_shadow[i] = 0;
        end
        m_send = 1'b0;
        m_idx = 0;
        hmp.delete();
        hinst.delete();
    endtask

    task automatic model_step();
        bit rpt, isc, isj;
        isc = (retire_inst[6:0] == 7'b1100011);
        isj = (retire_inst[6:0] == 7'b1101111) || (retire_inst[6:0] == 7'b1100111);
        rpt = RPT && mispredict && (hmp.size() == RD) && hmp[0] && (hinst[0] == mispredict_inst);
        hmp.push_back(mispredict);
        hinst.push_back(mispredict_inst);
        if (hmp.size() > RD) begin
            void'(hmp.pop_front());
            void'(hinst.pop_front());
        end
        if (!m_send) begin
            if (snap_req) begin
                m_shadow = m_cnt;
                m_send = 1'b1;
                m_idx = 0;
            end
        end else if (out_ready) begin
            if (m_idx == 7) m_send = 1'b0;
            else m_idx++;
        end
        if (clear) begin
            for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        end else if (count_en) begin
            m_cnt[0]++;
            if (retire_valid) m_cnt[1]++;
            if (retire_valid && (isc || isj)) m_cnt[2]++;
            if (retire_valid && isc) m_cnt[3]++;
            if (mispredict) m_cnt[4]++;
            if (rpt) m_cnt[5]++;
            if (stall) m_cnt[6]++;
            if (retire_valid && isj) m_cnt[7]++;
        end
    endtask

    task automatic check_outputs();
        chk("busy32", busy_a, m_send);
        chk("valid32", out_valid_a, m_send);
        chk("idx32", out_idx_a, m_send ? m_idx : 0);
        chk("data32", out_data_a, m_send ? sat(m_shadow[m_idx], 32) : 0);
        chk("last32", out_last_a, m_send && (m_idx == 7));
        chk("busy8", busy_b, m_send);
        chk("valid8", out_valid_b, m_send);
        chk("idx8", out_idx_b, m_send ? m_idx : 0);
        chk("data8", out_data_b, m_send ? sat(m_shadow[m_idx], 8) : 0);
        chk("last8", out_last_b, m_send && (m_idx == 7));
    endtask

    task automatic half_check();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic half_step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic tick();
        half_check();
        half_step();
    endtask

    task automatic idle_inputs();
        retire_valid = 1'b0; retire_inst = 32'h0; mispredict = 1'b0;
        mispredict_inst = 32'h0; stall = 1'b0; clear = 1'b0; snap_req = 1'b0;
        out_ready = 1'b0; count_en = 1'b1;
    endtask

    // asynchronous reset: outputs checked with no clock edge, released after one posedge
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic snap_stream(input bit rnd, input bit hold, output int ncyc);
        bit done;
        done = 1'b0;
        ncyc = 0;
        for (int i = 0; i < 8; i++) begin
            got32[i] = 32'hdeadbeef;
            got8[i] = 8'haa;
        end
        snap_req = 1'b1;
        out_ready = 1'b1;
        tick();
        ncyc++;
        if (!hold) snap_req = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            half_check();
            if (out_valid_a && out_ready) begin
                got32[out_idx_a] = out_data_a;
                got8[out_idx_b] = out_data_b;
                if (out_last_a) done = 1'b1;
            end
            half_step();
            ncyc++;
        end
        snap_req = 1'b0;
        out_ready = 1'b0;
        if (!done) chk("stream_timeout", 0, 1);
    endtask

    initial begin
        stim_t stim [13];
        beat_t beats [8];
        int    ncyc, nrv, nx;
        bit    was_wait, after_last, fell;
        logic [2:0]  sidx;
        logic [31:0] sdata;
        logic [31:0] ipool [4];
        logic [31:0] mpool [3];

        ipool = '{BEQ, JAL, JALR, ADD};
        mpool = '{MA, MB, 32'h00000063};
        for (int i = 0; i < 13; i++) begin
            stim[i].rv   = (i < 10);
            stim[i].inst = (i < 10) ? ((i % 2 == 0) ? BEQ : ADD) : 32'h0;
            stim[i].mp   = (i == 2);
            stim[i].snap = (i == 12);
        end
        beats = '{'{3'd0, 32'd12, 1'b0}, '{3'd1, 32'd10, 1'b0}, '{3'd2, 32'd5, 1'b0},
                  '{3'd3, 32'd5, 1'b0}, '{3'd4, 32'd1, 1'b0}, '{3'd5, 32'd0, 1'b0},
                  '{3'd6, 32'd0, 1'b0}, '{3'd7, 32'd0, 1'b1}};

        idle_inputs();
        rst_n = 1'b1;
        #2;

        // count accumulation from the table
        do_reset();
        for (int i = 0; i < 13; i++) begin
            retire_valid = stim[i].rv;
            retire_inst = stim[i].inst;
            mispredict = stim[i].mp;
            mispredict_inst = MA;
            snap_req = stim[i].snap;
            tick();
        end
        idle_inputs();
        out_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            half_check();
            chk("acc_idx", out_idx_a, beats[b].idx);
            chk("acc_data", out_data_a, beats[b].data);
            chk("acc_last", out_last_a, beats[b].last);
            half_step();
        end
        half_check();
        chk("acc_busy_fall", busy_a, 0);
        half_step();

        // repeat miss: same word four cycles apart
        idle_inputs();
        do_reset();
        mispredict = 1'b1; mispredict_inst = MA; tick();
        mispredict = 1'b0; mispredict_inst = 32'h0; repeat (3) tick();
        mispredict = 1'b1; mispredict_inst = MA; tick();
        mispredict = 1'b0; mispredict_inst = 32'h0; tick();
        snap_stream(1'b0, 1'b0, ncyc);
        chk("rpt_same", got32[5], RPT ? 1 : 0);
        chk("rpt_same_mp", got32[4], 2);

        // repeat miss: different words four cycles apart
        do_reset();
        mispredict = 1'b1; mispredict_inst = MA; tick();
        mispredict = 1'b0; mispredict_inst = 32'h0; repeat (3) tick();
        mispredict = 1'b1; mispredict_inst = MB; tick();
        mispredict = 1'b0; mispredict_inst = 32'h0; tick();
        snap_stream(1'b0, 1'b0, ncyc);
        chk("rpt_diff", got32[5], 0);

        // backpressure: ready toggles every other cycle
        do_reset();
        retire_valid = 1'b1; retire_inst = JAL; stall = 1'b1; repeat (5) tick();
        idle_inputs();
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        nx = 0; was_wait = 1'b0; after_last = 1'b0; fell = 1'b0; sidx = 3'd0; sdata = 32'h0;
        for (int c = 0; c < 40 && !fell; c++) begin
            out_ready = c[0];
            half_check();
            if (after_last) begin
                chk("bp_busy_fall", busy_a, 0);
                fell = 1'b1;
            end
            if (was_wait) begin
                chk("bp_hold_idx", out_idx_a, sidx);
                chk("bp_hold_data", out_data_a, sdata);
            end
            was_wait = out_valid_a && !out_ready;
            sidx = out_idx_a;
            sdata = out_data_a;
            if (out_valid_a && out_ready) begin
                nx++;
                if (out_last_a) after_last = 1'b1;
            end
            half_step();
        end
        chk("bp_xfers", nx, 8);
        chk("bp_ended", fell, 1);

        // snapshot atomicity: retire and snap_req held high during the stream
        idle_inputs();
        do_reset();
        repeat (20) tick();
        retire_valid = 1'b1; retire_inst = ADD;
        snap_stream(1'b1, 1'b1, nrv);
        retire_valid = 1'b0;
        chk("atom_cycles", got32[0], 20);
        chk("atom_retired", got32[1], 0);
        repeat (3) tick();
        snap_stream(1'b0, 1'b0, ncyc);
        chk("atom_later_retired", got32[1], nrv);
        chk("atom_later_cycles", got32[0], 20 + nrv + 3);

        // saturation on the 8-bit instance, then clear beats stall
        do_reset();
        stall = 1'b1;
        repeat (300) tick();
        stall = 1'b0;
        snap_stream(1'b0, 1'b0, ncyc);
        chk("sat8_cycles", got8[0], 255);
        chk("sat8_stall", got8[6], 255);
        chk("wide_stall", got32[6], 300);
        clear = 1'b1; stall = 1'b1; tick();
        clear = 1'b0; stall = 1'b0;
        snap_stream(1'b0, 1'b0, ncyc);
        chk("clear_stall", got32[6], 0);
        chk("clear_stall8", got8[6], 0);

        // async reset in the middle of a stream
        do_reset();
        repeat (7) tick();
        snap_req = 1'b1; tick(); snap_req = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        @(negedge clk);
        chk("ar_at_beat3", out_idx_a, 3);
        do_reset();
        chk("ar_valid", out_valid_a, 0);
        chk("ar_busy", busy_a, 0);
        out_ready = 1'b0;
        repeat (5) tick();
        snap_stream(1'b0, 1'b0, ncyc);
        chk("ar_cycles", got32[0], 5);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            retire_valid = ($urandom_range(0, 3) != 0);
            retire_inst = ($urandom_range(0, 4) == 4) ? $urandom : ipool[$urandom_range(0, 3)];
            mispredict = ($urandom_range(0, 2) == 0);
            mispredict_inst = mpool[$urandom_range(0, 2)];
            stall = ($urandom_range(0, 2) == 0);
            count_en = ($urandom_range(0, 7) != 0);
            clear = ($urandom_range(0, 99) == 0);
            snap_req = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
